jk_bank_sequencer: RTL and testbench

Sequences a bank of four `WIDTH`-bit JK flip-flop registers on behalf of two requesters. Each request selects one word and one bit-wise operation: load, set, clear or toggle. The block grants requesters round-robin and translates the operation into per-bit `j`/`k` drive for one clock. It then reads the word back and reports whether the result matches the expected value. It sits between requesting logic and the JK register bank; no other block drives the bank's `j`/`k`/enable inputs.

---
 rtl/jk_bank_sequencer_pkg.sv | 35 +++
 rtl/jk_op_decode.sv | 36 +++
 rtl/jk_bank_sequencer.sv | 128 ++++++++++++
 tb/tb_jk_bank_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_sequencer_pkg.sv
// jk_bank_sequencer_pkg
//   Shared definitions for the JK bank sequencer: operation and FSM state
//   encodings, bank geometry, and the two-requester round-robin pick.
package jk_bank_sequencer_pkg;

    localparam int WORDS = 4;   // bank depth, address is 2 bits
    localparam int AW    = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_e;

    // Winner id for a two-bit request vector. On a tie the requester that
    // was not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic w;
        case (req)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = ~last;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/jk_op_decode.sv
// jk_op_decode
//   Combinational translation of one bit-wise operation into JK drive and
//   the value the word should hold afterwards.
//   op       : operation (load/set/clear/toggle)
//   d        : operand / bit mask
//   old      : word value before the operation
//   j, k     : per-bit JK drive for one clock
//   expected : word value after the JK update
module jk_op_decode
    import jk_bank_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] old,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] expected
);

    always_comb begin
        j        = '0;
        k        = '0;
        expected = old;
        case (op)
            // j=d, k=~d forces every bit, so the whole word becomes d.
            OP_LOAD: begin j = d;  k = ~d; expected = d;        end
            OP_SET:  begin j = d;  k = '0; expected = old | d;  end
            OP_CLR:  begin j = '0; k = d;  expected = old & ~d; end
            OP_TGL:  begin j = d;  k = d;  expected = old ^ d;  end
            default: ;
        endcase
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Arbitrates two requesters round-robin onto a four-word JK register bank,
//   drives the selected word for one clock, then reads it back and reports
//   whether it holds the expected value.
//   clk, clear        : rising-edge clock, async active-high reset
//   req[1:0]          : per-requester request, held until ack
//   op0/op1           : operation per requester
//   addr0/addr1       : target word per requester
//   data0/data1       : operand / mask per requester
//   ack[1:0]          : one-cycle completion pulse to the served requester
//   err               : with ack, 1 = read-back mismatch
//   bank_sel          : one-hot word enable (DRIVE only)
//   bank_j, bank_k    : shared JK drive (DRIVE only)
//   bank_q            : Q of all words, word w at [w*WIDTH +: WIDTH]
//   bank_clr          : bank clear, follows clear
module jk_bank_sequencer
    import jk_bank_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = jk_bank_sequencer_pkg::WORDS
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [1:0]             req,
    input  logic [1:0]             op0,
    input  logic [1:0]             op1,
    input  logic [1:0]             addr0,
    input  logic [1:0]             addr1,
    input  logic [WIDTH-1:0]       data0,
    input  logic [WIDTH-1:0]       data1,
    output logic [1:0]             ack,
    output logic                   err,
    output logic [WORDS-1:0]       bank_sel,
    output logic [WIDTH-1:0]       bank_j,
    output logic [WIDTH-1:0]       bank_k,
    input  logic [WORDS*WIDTH-1:0] bank_q,
    output logic                   bank_clr
);

    state_e           state, state_d;
    logic             last;       // id served most recently
    logic             cap_id;
    op_e              cap_op;
    logic [AW-1:0]    cap_addr;
    logic [WIDTH-1:0] cap_data;
    logic [WIDTH-1:0] cap_old;

    logic             grant;
    logic             start;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] new_word;   // bank word at the arbitrating addr
    logic [WIDTH-1:0] rd_word;    // bank word at the captured addr
    logic [WIDTH-1:0] dec_j, dec_k, dec_exp;

    assign bank_clr = clear;

    assign grant    = rr_pick(req, last);
    assign start    = (state == ST_IDLE) && (req != 2'b00);
    assign sel_addr = grant ? addr1 : addr0;
    assign new_word = bank_q[int'(sel_addr)*WIDTH +: WIDTH];
    assign rd_word  = bank_q[int'(cap_addr)*WIDTH +: WIDTH];

    jk_op_decode #(.WIDTH(WIDTH)) u_dec (
        .op       (cap_op),
        .d        (cap_data),
        .old      (cap_old),
        .j        (dec_j),
        .k        (dec_k),
        .expected (dec_exp)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Request capture and arbitration history. old is snapshotted here so
    // the expected value reflects the word before the DRIVE edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            last     <= 1'b1;
            cap_id   <= 1'b0;
            cap_op   <= OP_LOAD;
            cap_addr <= '0;
            cap_data <= '0;
            cap_old  <= '0;
        end else if (start) begin
            last     <= grant;
            cap_id   <= grant;
            cap_op   <= op_e'(grant ? op1 : op0);
            cap_addr <= sel_addr;
            cap_data <= grant ? data1 : data0;
            cap_old  <= new_word;
        end
    end

    always_comb begin
        state_d  = state;
        bank_sel = '0;
        bank_j   = '0;
        bank_k   = '0;
        ack      = 2'b00;
        err      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                bank_sel[cap_addr] = 1'b1;
                bank_j             = dec_j;
                bank_k             = dec_k;
                state_d            = ST_CHECK;
            end
            ST_CHECK: begin
                // The bank updated on the edge that ended DRIVE, so bank_q
                // already shows the result here.
                ack[cap_id] = 1'b1;
                err         = (rd_word != dec_exp);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer
//   Directed bench: a behavioural JK bank around the sequencer, hand-computed
//   expected values, immediate assertions at each comparison.
module tb_jk_bank_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic [1:0]  req;
    logic [1:0]  op0, op1, addr0, addr1;
    logic [7:0]  data0, data1;
    logic [1:0]  ack;
    logic        err;
    logic [3:0]  bank_sel;
    logic [7:0]  bank_j, bank_k;
    logic [31:0] bank_q;
    logic        bank_clr;

    logic [3:0][7:0] model_q;
    logic            stuck3;

    int checks = 0;
    int errors = 0;

    logic [3:0] sel_seen;
    logic [7:0] j_seen, k_seen;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.WIDTH(8), .WORDS(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .req      (req),
        .op0      (op0),
        .op1      (op1),
        .addr0    (addr0),
        .addr1    (addr1),
        .data0    (data0),
        .data1    (data1),
        .ack      (ack),
        .err      (err),
        .bank_sel (bank_sel),
        .bank_j   (bank_j),
        .bank_k   (bank_k),
        .bank_q   (bank_q),
        .bank_clr (bank_clr)
    );

    // Behavioural JK register bank; word 3 can be held stuck at zero.
    assign bank_q = model_q;
    always @(posedge clk or posedge bank_clr) begin
        if (bank_clr) begin
            model_q <= '0;
        end else begin
            for (int w = 0; w < 4; w++)
                if (bank_sel[w])
                    model_q[w] <= (bank_j & ~model_q[w]) | (~bank_k & model_q[w]);
            if (stuck3) model_q[3] <= 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-requester transaction; checks ack id, err and latency and
    // records the DRIVE-cycle outputs.
    task automatic txn(input int id, input logic [1:0] op, input logic [1:0] a,
                       input logic [7:0] d, input logic exp_err, input string tag);
        int cyc;
        @(posedge clk); #1;
        if (id == 0) begin op0 = op; addr0 = a; data0 = d; req = 2'b01; end
        else         begin op1 = op; addr1 = a; data1 = d; req = 2'b10; end
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin sel_seen = bank_sel; j_seen = bank_j; k_seen = bank_k; end
            if (ack != 2'b00) break;
        end
        chk({tag, " ack"}, ack, (id == 0) ? 2'b01 : 2'b10);
        chk({tag, " err"}, err, exp_err);
        chk({tag, " latency"}, cyc, 2);
        req = 2'b00;
    endtask

    initial begin
        int n, prev, cyc;
        clear = 1'b1; req = 2'b00; stuck3 = 1'b0;
        op0 = 2'b00; op1 = 2'b00; addr0 = 2'b00; addr1 = 2'b00;
        data0 = 8'h00; data1 = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst ack", ack, 2'b00);
        chk("rst err", err, 1'b0);
        chk("rst sel", bank_sel, 4'h0);
        chk("rst j", bank_j, 8'h00);
        chk("rst k", bank_k, 8'h00);
        chk("rst bank_clr", bank_clr, 1'b1);
        @(posedge clk); #1 clear = 1'b0;
        chk("bank_clr low", bank_clr, 1'b0);

        // Load A5 to word 2 from requester 0
        txn(0, 2'b00, 2'd2, 8'hA5, 1'b0, "load");
        chk("load sel", sel_seen, 4'b0100);
        chk("load j", j_seen, 8'hA5);
        chk("load k", k_seen, 8'h5A);
        chk("load w2", model_q[2], 8'hA5);
        chk("load w0", model_q[0], 8'h00);
        chk("load w1", model_q[1], 8'h00);
        chk("load w3", model_q[3], 8'h00);

        // Set/clear/toggle chain on word 1; toggle by requester 1 so that
        // requester 0 is owed the next tie.
        txn(0, 2'b00, 2'd1, 8'h0F, 1'b0, "w1 init");
        chk("w1 init val", model_q[1], 8'h0F);
        txn(0, 2'b01, 2'd1, 8'hF0, 1'b0, "set");
        chk("set j", j_seen, 8'hF0);
        chk("set k", k_seen, 8'h00);
        chk("set val", model_q[1], 8'hFF);
        txn(0, 2'b10, 2'd1, 8'h3C, 1'b0, "clr");
        chk("clr j", j_seen, 8'h00);
        chk("clr k", k_seen, 8'h3C);
        chk("clr val", model_q[1], 8'hC3);
        txn(1, 2'b11, 2'd1, 8'hFF, 1'b0, "tgl");
        chk("tgl sel", sel_seen, 4'b0010);
        chk("tgl j", j_seen, 8'hFF);
        chk("tgl k", k_seen, 8'hFF);
        chk("tgl val", model_q[1], 8'h3C);

        // Fairness: both hold req for six transactions
        @(posedge clk); #1;
        op0 = 2'b00; addr0 = 2'd0; data0 = 8'h55;
        op1 = 2'b00; addr1 = 2'd3; data1 = 8'hAA;
        req = 2'b11;
        n = 0; prev = 0;
        for (cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                chk("fair order", ack, (n % 2 == 0) ? 2'b01 : 2'b10);
                chk("fair err", err, 1'b0);
                if (n == 0) chk("fair first lat", cyc, 2);
                else        chk("fair spacing", cyc - prev, 3);
                prev = cyc;
                n++;
                if (n == 6) req = 2'b00;
            end
        end
        chk("fair count", n, 6);
        chk("fair w0", model_q[0], 8'h55);
        chk("fair w3", model_q[3], 8'hAA);

        // Error detect: word 3 stuck at zero
        stuck3 = 1'b1;
        txn(1, 2'b00, 2'd3, 8'h01, 1'b1, "stuck");
        chk("stuck w3", model_q[3], 8'h00);
        stuck3 = 1'b0;

        // Reset in the middle of DRIVE
        @(posedge clk); #1;
        op0 = 2'b00; addr0 = 2'd1; data0 = 8'h77; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("mid drive sel", bank_sel, 4'b0010);
        clear = 1'b1;
        #1;
        chk("mid sel", bank_sel, 4'h0);
        chk("mid j", bank_j, 8'h00);
        chk("mid k", bank_k, 8'h00);
        chk("mid ack", ack, 2'b00);
        op1 = 2'b00; addr1 = 2'd2; data1 = 8'h99; req = 2'b11;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack != 2'b00) n++;
        end
        chk("mid no ack", n, 0);
        chk("mid w1", model_q[1], 8'h00);
        chk("mid w0", model_q[0], 8'h00);
        chk("mid w3", model_q[3], 8'h00);
        @(posedge clk); #1 clear = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (ack != 2'b00) break;
        end
        chk("post tie ack", ack, 2'b01);
        chk("post tie lat", cyc, 2);
        chk("post tie err", err, 1'b0);
        req = 2'b10;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (ack != 2'b00) break;
        end
        chk("post r1 ack", ack, 2'b10);
        chk("post r1 gap", cyc, 2);
        req = 2'b00;
        chk("post w1", model_q[1], 8'h77);
        chk("post w2", model_q[2], 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
